// File: rtl/cpu_pkg.sv
// Shared definitions for the core: next-PC select codes, instruction
// field positions and the fetch-stage state encoding.
package cpu_pkg;

  // Next-PC select codes driven by the controller.
  localparam logic [1:0] CP_SEQ = 2'b00;
  localparam logic [1:0] CP_JR  = 2'b01;
  localparam logic [1:0] CP_J   = 2'b10;
  localparam logic [1:0] CP_BR  = 2'b11;

  // Instruction field positions.
  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int TGT_MSB   = 25;
  localparam int TGT_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_READY = 2'b10
  } fetch_state_t;

  // Branch displacement: sign-extended 16-bit word offset turned into bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection. All adds are 32-bit with the carry
// dropped, so the PC wraps naturally at the top of the address space.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [1:0]  cp_type,
  input  logic        enbranch,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  // The opcode field plays no part in target computation.
  logic unused_opc_s;
  assign unused_opc_s = ^instr[OPC_MSB:OPC_LSB];

  assign pc_plus4 = pc + 32'd4;

  // Select the next PC from the controller's decision.
  always_comb begin
    next_pc = pc_plus4;
    case (cp_type)
      CP_SEQ: next_pc = pc_plus4;
      CP_JR:  next_pc = {jr_target[31:2], 2'b00};
      CP_J:   next_pc = {pc_plus4[31:28], instr[TGT_MSB:TGT_LSB], 2'b00};
      CP_BR: begin
        if (enbranch) begin
          next_pc = pc_plus4 + branch_offset(instr[IMM_MSB:IMM_LSB]);
        end else begin
          next_pc = pc_plus4;
        end
      end
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one instruction over a
// req/ack memory handshake and advances the PC when the controller
// signals that the current instruction is finished.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        write_pc,
  input  logic [1:0]  cp_type,
  input  logic        enbranch,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [5:0]  opecode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] retired
);

  fetch_state_t state_r, state_n;
  logic [31:0]  pc_r, pc_n;
  logic [31:0]  instr_r, instr_n;
  logic         valid_r, valid_n;
  logic         req_r, req_n;
  logic [31:0]  retired_r, retired_n;
  logic [31:0]  next_pc_s;

  next_pc_calc u_next_pc (
    .pc        (pc_r),
    .instr     (instr_r),
    .cp_type   (cp_type),
    .enbranch  (enbranch),
    .jr_target (jr_target),
    .pc_plus4  (pc_plus4),
    .next_pc   (next_pc_s)
  );

  // State and datapath registers; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      pc_r      <= RESET_PC;
      instr_r   <= 32'h0000_0000;
      valid_r   <= 1'b0;
      req_r     <= 1'b0;
      retired_r <= 32'h0000_0000;
    end else begin
      state_r   <= state_n;
      pc_r      <= pc_n;
      instr_r   <= instr_n;
      valid_r   <= valid_n;
      req_r     <= req_n;
      retired_r <= retired_n;
    end
  end

  // Next-state logic; acks are only honoured in FETCH, strobes only in READY.
  always_comb begin
    state_n   = state_r;
    pc_n      = pc_r;
    instr_n   = instr_r;
    valid_n   = valid_r;
    req_n     = req_r;
    retired_n = retired_r;
    case (state_r)
      ST_IDLE: begin
        req_n   = 1'b1;
        state_n = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          instr_n = imem_rdata;
          valid_n = 1'b1;
          req_n   = 1'b0;
          state_n = ST_READY;
        end else begin
          req_n   = 1'b1;
          state_n = ST_FETCH;
        end
      end
      ST_READY: begin
        if (write_pc) begin
          pc_n      = next_pc_s;
          valid_n   = 1'b0;
          retired_n = retired_r + 32'd1;
          req_n     = 1'b1;
          state_n   = ST_FETCH;
        end else begin
          state_n = ST_READY;
        end
      end
      default: begin
        req_n   = 1'b0;
        valid_n = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign instr       = instr_r;
  assign opecode     = instr_r[OPC_MSB:OPC_LSB];
  assign funct       = instr_r[FUNCT_MSB:FUNCT_LSB];
  assign instr_valid = valid_r;
  assign retired     = retired_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of fetch/advance steps followed
// by hand-written sequences for the handshake and reset corner cases.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        write_pc;
  logic [1:0]  cp_type;
  logic        enbranch;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic [5:0]  opecode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] retired;

  int total = 0;
  int bad = 0;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .write_pc    (write_pc),
    .cp_type     (cp_type),
    .enbranch    (enbranch),
    .jr_target   (jr_target),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr       (instr),
    .opecode     (opecode),
    .funct       (funct),
    .instr_valid (instr_valid),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    int          waits;
    logic [1:0]  cp;
    logic        en;
    logic [31:0] jr;
    logic [31:0] exp_pc;
    logic [5:0]  exp_opc;
    logic [5:0]  exp_funct;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{32'h2008_0005, 3, 2'b00, 1'b0, 32'h0, 32'h100, 6'h08, 6'h05, 32'h104};
    vecs[1] = '{32'h0800_0040, 0, 2'b10, 1'b0, 32'h0, 32'h104, 6'h02, 6'h00, 32'h100};
    vecs[2] = '{32'h0000_0008, 1, 2'b01, 1'b0, 32'h203, 32'h100, 6'h00, 6'h08, 32'h200};
    vecs[3] = '{32'h1000_FFFE, 0, 2'b11, 1'b1, 32'h0, 32'h200, 6'h04, 6'h3E, 32'h1FC};
    vecs[4] = '{32'h03E0_0008, 2, 2'b01, 1'b0, 32'h200, 32'h1FC, 6'h00, 6'h08, 32'h200};
    vecs[5] = '{32'h1000_FFFE, 0, 2'b11, 1'b0, 32'h0, 32'h200, 6'h04, 6'h3E, 32'h204};
    vecs[6] = '{32'h1000_0003, 1, 2'b11, 1'b1, 32'h0, 32'h204, 6'h04, 6'h03, 32'h214};

    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; write_pc = 1'b0;
    cp_type = 2'b00; enbranch = 1'b0; jr_target = 32'h0;
    cyc(); cyc();
    chk("rst_pc", pc, 32'h100);
    chk("rst_pc_plus4", pc_plus4, 32'h104);
    chk("rst_instr", instr, 32'h0);
    chk("rst_opecode", {26'h0, opecode}, 32'h0);
    chk("rst_funct", {26'h0, funct}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_retired", retired, 32'h0);
    rst = 1'b0;
    cyc();
    chk("req_after_reset", {31'h0, imem_req}, 32'h1);

    // Table: fetch with wait states, then advance the PC.
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_pc);
      for (int w = 0; w < vecs[i].waits; w++) cyc();
      chk($sformatf("v%0d_wait_req", i), {31'h0, imem_req}, 32'h1);
      chk($sformatf("v%0d_wait_valid", i), {31'h0, instr_valid}, 32'h0);
      imem_ack = 1'b1; imem_rdata = vecs[i].rdata;
      cyc();
      imem_ack = 1'b0; imem_rdata = 32'h0;
      chk($sformatf("v%0d_valid", i), {31'h0, instr_valid}, 32'h1);
      chk($sformatf("v%0d_instr", i), instr, vecs[i].rdata);
      chk($sformatf("v%0d_opecode", i), {26'h0, opecode}, {26'h0, vecs[i].exp_opc});
      chk($sformatf("v%0d_funct", i), {26'h0, funct}, {26'h0, vecs[i].exp_funct});
      chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_pc_plus4", i), pc_plus4, vecs[i].exp_pc + 32'd4);
      chk($sformatf("v%0d_req_low", i), {31'h0, imem_req}, 32'h0);
      write_pc = 1'b1; cp_type = vecs[i].cp; enbranch = vecs[i].en; jr_target = vecs[i].jr;
      cyc();
      write_pc = 1'b0; cp_type = 2'b00; enbranch = 1'b0; jr_target = 32'h0;
      chk($sformatf("v%0d_next_pc", i), pc, vecs[i].exp_next);
      chk($sformatf("v%0d_next_addr", i), imem_addr, vecs[i].exp_next);
      chk($sformatf("v%0d_retired", i), retired, 32'(i + 1));
      chk($sformatf("v%0d_refetch_req", i), {31'h0, imem_req}, 32'h1);
      chk($sformatf("v%0d_valid_drop", i), {31'h0, instr_valid}, 32'h0);
    end

    // write_pc during FETCH is ignored.
    write_pc = 1'b1; cp_type = 2'b00;
    cyc();
    write_pc = 1'b0;
    chk("fetch_wpc_pc", pc, 32'h214);
    chk("fetch_wpc_retired", retired, 32'd7);
    chk("fetch_wpc_req", {31'h0, imem_req}, 32'h1);

    // Stray ack in READY leaves the instruction alone.
    imem_ack = 1'b1; imem_rdata = 32'h0000_0008;
    cyc();
    imem_rdata = 32'hFFFF_FFFF;
    cyc();
    imem_ack = 1'b0;
    chk("stray_ack_instr", instr, 32'h0000_0008);
    chk("stray_ack_valid", {31'h0, instr_valid}, 32'h1);
    chk("stray_ack_req", {31'h0, imem_req}, 32'h0);

    // PC wrap: jump to the last word, then sequential step to zero.
    write_pc = 1'b1; cp_type = 2'b01; jr_target = 32'hFFFF_FFFF;
    cyc();
    write_pc = 1'b0; cp_type = 2'b00; jr_target = 32'h0;
    chk("wrap_top_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_top_plus4", pc_plus4, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h0;
    cyc();
    imem_ack = 1'b0;
    write_pc = 1'b1;
    cyc();
    write_pc = 1'b0;
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_retired", retired, 32'd9);

    // Reset while FETCH waits; late ack just after release is ignored.
    cyc();
    rst = 1'b1;
    #1;
    chk("midfetch_rst_req", {31'h0, imem_req}, 32'h0);
    cyc();
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    cyc();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    chk("late_ack_valid", {31'h0, instr_valid}, 32'h0);
    chk("late_ack_instr", instr, 32'h0);
    chk("late_ack_pc", pc, 32'h100);
    chk("late_ack_retired", retired, 32'h0);
    chk("fresh_req", {31'h0, imem_req}, 32'h1);
    imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    cyc();
    imem_ack = 1'b0;
    chk("fresh_valid", {31'h0, instr_valid}, 32'h1);
    chk("fresh_instr", instr, 32'h2008_0005);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the multi-cycle core. Holds the PC, fetches one instruction per cycle of the controller's step sequence over a req/ack instruction-memory handshake, and presents `opecode`/`funct` to the controller. Computes the next PC from the controller's `cp_type`/`enbranch` decision when the controller pulses `write_pc`.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_req`  out  1  fetch request; registered.
- `imem_addr`  out  32  word-aligned fetch address, equal to `pc`.
- `imem_ack`  in  1  memory response valid; `imem_rdata` valid in the same cycle.
- `imem_rdata`  in  32  fetched instruction.
- `write_pc`  in  1  controller strobe: current instruction finished, advance PC.
- `cp_type`  in  2  next-PC select: 00 seq, 01 register jump, 10 jump, 11 branch.
- `enbranch`  in  1  branch taken, used only when `cp_type`=11.
- `jr_target`  in  32  register value for `cp_type`=01.
- `pc`  out  32  address of the held instruction.
- `pc_plus4`  out  32  `pc`+4, link value.
- `instr`  out  32  instruction register.
- `opecode`  out  6  `instr[31:26]`.
- `funct`  out  6  `instr[5:0]`.
- `instr_valid`  out  1  `instr` holds the instruction at `pc`.
- `retired`  out  32  count of accepted `write_pc` strobes.

## Operation
- States: IDLE, FETCH, READY.
- IDLE: entered on reset. Next edge: `imem_req`<=1, go to FETCH.
- FETCH: `imem_req`=1, `imem_addr`=`pc`, both stable until ack. On an edge with `imem_ack`=1: `instr`<=`imem_rdata`, `instr_valid`<=1, `imem_req`<=0, go to READY.
- READY: hold `instr`. On an edge with `write_pc`=1:
  - `pc`<=next PC
  - `instr_valid`<=0
  - `retired`<=`retired`+1, wrapping modulo 2^32
  - `imem_req`<=1
  - go to FETCH
- Next PC, all arithmetic 32-bit with carry discarded:
  - 00: `pc`+4.
  - 01: `jr_target` with bits [1:0] forced to 0.
  - 10: {`pc_plus4`[31:28], `instr`[25:0], 2'b00}.
  - 11: if `enbranch`, `pc_plus4` + (sign-extend(`instr`[15:0]) << 2); otherwise `pc`+4.
- `write_pc` in IDLE or FETCH is ignored: no PC change, no count.
- `imem_ack` while `imem_req`=0 is ignored.
- PC wraps 32'hFFFF_FFFC -> 0.
- Reset mid-fetch abandons the request. `imem_req` drops immediately. A late ack is ignored because it arrives in IDLE.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4
  - `instr`=0, `opecode`=0, `funct`=0
  - `instr_valid`=0, `imem_req`=0, `retired`=0
  - state IDLE
- `imem_req` rises 1 cycle after reset release.
- Fetch latency: `instr_valid` rises on the edge sampling `imem_ack`=1, so at minimum 1 cycle after `imem_req` rises.
- `write_pc` to next `imem_req`: 1 edge. Peak rate is one instruction per 2 cycles with zero-wait memory.
- `opecode`, `funct` and `pc_plus4` are combinational from registers and glitch-free between edges.
- `cp_type`, `enbranch` and `jr_target` are sampled only on the `write_pc` edge.

## Structure
- Shared package `cpu_pkg`:
  - `CP_SEQ`=2'b00, `CP_JR`=2'b01, `CP_J`=2'b10, `CP_BR`=2'b11
  - field-position constants for opcode, funct, imm16, target26
  - fetch state enum
- Sub-module `next_pc_calc`: combinational next-PC mux and adder (inputs `pc`, `instr`, `cp_type`, `enbranch`, `jr_target`), tested standalone.

## Test plan
- Reset with `RESET_PC`=0x100, then ack after 3 wait cycles with rdata 0x2008_0005 -> `imem_req` high from cycle 1; `instr_valid`=1, `opecode`=6'b001000, `pc`=0x100.
- `write_pc` with `cp_type`=00 -> next `imem_addr`=0x104, `retired`=1.
- At `pc`=0x104, instr 0x0800_0040, `cp_type`=10 -> next `pc`=0x100. Then `cp_type`=01 with `jr_target`=0x203 -> `pc`=0x200.
- At `pc`=0x200, instr 0x1000_FFFE, `cp_type`=11:
  - `enbranch`=1 -> `pc`=0x1FC
  - `enbranch`=0 -> `pc`=0x204
- `write_pc` pulsed during FETCH -> `pc` and `retired` unchanged.
- Stray `imem_ack` in READY -> `instr` unchanged.
- Assert `rst` while FETCH is waiting, then ack 1 cycle after release -> ack ignored; `pc`=`RESET_PC`; fresh request issued.
